mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage.sv | 113 +++++++++++
 tb/tb_mem_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bundle of EXE->MEM, MEM->WB, MEM->ID and data-SRAM response signals for the memory stage.
// The slave side belongs to mem_stage; the master side is its surrounding pipeline.
interface mem_stage_if;
    localparam int EXE_TO_MEM_WD = 74;
    localparam int MEM_TO_WB_WD  = 70;
    localparam int MEM_TO_ID_WD  = 39;

    logic                     mem_allowin;
    logic                     exe_to_mem_valid;
    logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus;
    logic                     wb_allowin;
    logic                     mem_to_wb_valid;
    logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus;
    logic                     data_sram_rvalid;
    logic [31:0]              data_sram_rdata;
    logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus;

    modport slave (
        input  exe_to_mem_valid, exe_to_mem_bus, wb_allowin,
        input  data_sram_rvalid, data_sram_rdata,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
    );

    modport master (
        output exe_to_mem_valid, exe_to_mem_bus, wb_allowin,
        output data_sram_rvalid, data_sram_rdata,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction, waits for load data, extracts and
// sign/zero-extends the loaded value, and forwards results to WB and ID.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  pipe
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic        mem_valid_reg;
    logic [73:0] mem_data_reg;
    logic [1:0]  state_reg;
    logic [31:0] rbuf_reg;

    logic        ld_en;
    logic [2:0]  ld_op;
    logic        reg_w;
    logic [4:0]  reg_waddr;
    logic [31:0] exe_result;
    logic [31:0] pc;

    assign ld_en      = mem_data_reg[73];
    assign ld_op      = mem_data_reg[72:70];
    assign reg_w      = mem_data_reg[69];
    assign reg_waddr  = mem_data_reg[68:64];
    assign exe_result = mem_data_reg[63:32];
    assign pc         = mem_data_reg[31:0];

    logic mem_ready_go;
    logic mem_allowin;
    logic mem_accept;
    logic mem_leave;

    assign mem_ready_go = ~ld_en | (state_reg == ST_DONE)
                        | ((state_reg == ST_WAIT) & pipe.data_sram_rvalid);
    assign mem_allowin  = ~mem_valid_reg | (mem_ready_go & pipe.wb_allowin);
    assign mem_accept   = pipe.exe_to_mem_valid & mem_allowin;
    assign mem_leave    = mem_valid_reg & mem_ready_go & pipe.wb_allowin;

    // Entry state of a newly accepted instruction overrides whatever the old one was doing.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
            rbuf_reg      <= 32'h0;
        end else begin
            if (mem_allowin) begin
                mem_valid_reg <= pipe.exe_to_mem_valid;
            end
            if (mem_accept) begin
                state_reg <= pipe.exe_to_mem_bus[73] ? ST_WAIT : ST_IDLE;
            end else if (mem_leave) begin
                state_reg <= ST_IDLE;
            end else if (mem_valid_reg && state_reg == ST_WAIT && pipe.data_sram_rvalid) begin
                state_reg <= ST_DONE;
                rbuf_reg  <= pipe.data_sram_rdata;
            end
        end
    end

    // Payload needs no reset: every consumer is qualified by mem_valid_reg.
    always_ff @(posedge clk) begin
        if (mem_accept) begin
            mem_data_reg <= pipe.exe_to_mem_bus;
        end
    end

    logic [31:0] raw_word;
    logic [7:0]  raw_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ld_value;
    logic [31:0] reg_wdata;

    assign raw_word = (state_reg == ST_DONE) ? rbuf_reg : pipe.data_sram_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign raw_byte[gi] = raw_word[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = raw_byte[exe_result[1:0]];
    assign sel_half = exe_result[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        ld_value = 32'h0;
        case (ld_op)
            3'b000:  ld_value = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  ld_value = {{16{sel_half[15]}}, sel_half};
            3'b010:  ld_value = raw_word;
            3'b100:  ld_value = {24'h0, sel_byte};
            3'b101:  ld_value = {16'h0, sel_half};
            default: ld_value = 32'h0;
        endcase
    end

    assign reg_wdata = ld_en ? ld_value : exe_result;

    logic fwd_valid;
    logic ld_pending;

    assign fwd_valid  = mem_valid_reg & reg_w & mem_ready_go;
    assign ld_pending = mem_valid_reg & reg_w & ld_en & ~mem_ready_go;

    assign pipe.mem_allowin     = mem_allowin;
    assign pipe.mem_to_wb_valid = mem_valid_reg & mem_ready_go;
    assign pipe.mem_to_wb_bus   = {reg_w, reg_waddr, reg_wdata, pc};
    assign pipe.mem_to_id_bus   = {fwd_valid, ld_pending, reg_waddr, reg_wdata};
endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a transaction-level model:
// one occupant instruction, optionally with a captured load word.
module tb_mem_stage;
    typedef struct packed {
        logic        ld_en;
        logic [2:0]  op;
        logic        regw;
        logic [4:0]  waddr;
        logic [31:0] result;
        logic [31:0] pc;
    } ins_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_stage_if intf ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .pipe   (intf.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Model of the stage: occupancy, the occupant, and a load word captured while WB stalled.
    logic        m_valid = 1'b0;
    ins_t        m_ins   = '0;
    logic        m_have  = 1'b0;
    logic [31:0] m_word  = 32'h0;
    logic [31:0] pc_q [$];

    logic        obs_allowin, obs_wb_valid, obs_fwd, obs_pending;
    logic [31:0] obs_wdata;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_value(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = w >> (8 * a);
        b = shifted[7:0];
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return w;
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    function automatic ins_t mk(input logic ld, input logic [2:0] op, input logic regw,
                                input logic [4:0] wa, input logic [31:0] res, input logic [31:0] pc);
        ins_t t;
        t.ld_en = ld; t.op = op; t.regw = regw; t.waddr = wa; t.result = res; t.pc = pc;
        return t;
    endfunction

    task automatic step(input logic rst_n, input logic ev, input ins_t ins,
                        input logic wba, input logic rv, input logic [31:0] rd);
        logic        ready, exp_allow, exp_wbv;
        logic [31:0] word, wdata, exp_pc;
        @(negedge clk);
        resetn                = rst_n;
        intf.exe_to_mem_valid = ev;
        intf.exe_to_mem_bus   = ins;
        intf.wb_allowin       = wba;
        intf.data_sram_rvalid = rv;
        intf.data_sram_rdata  = rd;
        #1;
        ready     = !m_ins.ld_en || m_have || rv;
        word      = m_have ? m_word : rd;
        wdata     = m_ins.ld_en ? ld_value(m_ins.op, m_ins.result[1:0], word) : m_ins.result;
        exp_allow = !m_valid || (ready && wba);
        exp_wbv   = m_valid && ready;

        obs_allowin  = intf.mem_allowin;
        obs_wb_valid = intf.mem_to_wb_valid;
        obs_wdata    = intf.mem_to_wb_bus[63:32];
        obs_fwd      = intf.mem_to_id_bus[38];
        obs_pending  = intf.mem_to_id_bus[37];

        check("allowin", 70'(intf.mem_allowin), 70'(exp_allow));
        check("wb_valid", 70'(intf.mem_to_wb_valid), 70'(exp_wbv));
        check("fwd_valid", 70'(intf.mem_to_id_bus[38]), 70'(m_valid && m_ins.regw && ready));
        check("ld_pending", 70'(intf.mem_to_id_bus[37]),
              70'(m_valid && m_ins.regw && m_ins.ld_en && !ready));
        if (m_valid) check("id_waddr", 70'(intf.mem_to_id_bus[36:32]), 70'(m_ins.waddr));
        if (exp_wbv) begin
            check("wb_bus", intf.mem_to_wb_bus, {m_ins.regw, m_ins.waddr, wdata, m_ins.pc});
            check("fwd_data", 70'(intf.mem_to_id_bus[31:0]), 70'(wdata));
        end
        if (exp_wbv && wba) begin
            exp_pc = (pc_q.size() != 0) ? pc_q.pop_front() : ~intf.mem_to_wb_bus[31:0];
            check("retire_pc", 70'(intf.mem_to_wb_bus[31:0]), 70'(exp_pc));
        end

        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_have  = 1'b0;
            pc_q.delete();
        end else if (exp_allow) begin
            m_valid = ev;
            m_ins   = ins;
            m_have  = 1'b0;
            if (ev) pc_q.push_back(ins.pc);
        end else if (m_ins.ld_en && !m_have && rv) begin
            m_have = 1'b1;
            m_word = rd;
        end
    endtask

    function automatic ins_t rand_ins();
        return mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom), $urandom, $urandom);
    endfunction

    initial begin
        ins_t nop;
        nop = '0;
        resetn                = 1'b0;
        intf.exe_to_mem_valid = 1'b0;
        intf.exe_to_mem_bus   = '0;
        intf.wb_allowin       = 1'b1;
        intf.data_sram_rvalid = 1'b0;
        intf.data_sram_rdata  = 32'h0;
        repeat (3) @(posedge clk);

        // First cycle after reset release: empty and accepting.
        step(1, 0, nop, 1, 1, 32'hDEAD_BEEF);
        check("rst_allowin", 70'(obs_allowin), 70'(1));
        check("rst_wb_valid", 70'(obs_wb_valid), 70'(0));
        check("rst_pending", 70'(obs_pending), 70'(0));

        // ALU op retires the cycle after acceptance.
        step(1, 1, mk(0, 3'd0, 1, 5'd5, 32'h1234_5678, 32'h1c00_0000), 1, 0, 32'h0);
        step(1, 0, nop, 1, 0, 32'h0);
        check("alu_wb_valid", 70'(obs_wb_valid), 70'(1));
        check("alu_wdata", 70'(obs_wdata), 70'(32'h1234_5678));
        check("alu_fwd", 70'(obs_fwd), 70'(1));

        // ld.b from byte 3 with data in the first MEM cycle.
        step(1, 1, mk(1, 3'd0, 1, 5'd6, 32'h0000_1003, 32'h1c00_0004), 1, 0, 32'h0);
        step(1, 0, nop, 1, 1, 32'h80FF_0011);
        check("ldb_wb_valid", 70'(obs_wb_valid), 70'(1));
        check("ldb_wdata", 70'(obs_wdata), 70'(32'hFFFF_FF80));

        // ld.hu from halfword 1, data three cycles late.
        step(1, 1, mk(1, 3'd5, 1, 5'd7, 32'h0000_2002, 32'h1c00_0008), 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, nop, 1, 0, 32'h5555_5555);
            check("ldhu_pending", 70'(obs_pending), 70'(1));
            check("ldhu_allowin", 70'(obs_allowin), 70'(0));
        end
        step(1, 0, nop, 1, 1, 32'h8001_7777);
        check("ldhu_wdata", 70'(obs_wdata), 70'(32'h0000_8001));

        // ld.w captured while WB stalls; later rdata changes must not leak through.
        step(1, 1, mk(1, 3'd2, 1, 5'd8, 32'h0000_3000, 32'h1c00_000c), 1, 0, 32'h0);
        step(1, 0, nop, 0, 1, 32'hCAFE_0001);
        step(1, 0, nop, 0, 1, 32'h1111_2222);
        check("ldw_hold", 70'(obs_wdata), 70'(32'hCAFE_0001));
        step(1, 0, nop, 1, 0, 32'h3333_4444);
        check("ldw_exit_valid", 70'(obs_wb_valid), 70'(1));
        check("ldw_exit_data", 70'(obs_wdata), 70'(32'hCAFE_0001));

        // Back-to-back ALU ops: one retire per cycle.
        for (int i = 0; i < 6; i++) begin
            step(1, 1, mk(0, 3'd0, 1, 5'(i), 32'(i * 3), 32'h1c00_0100 + 32'(i * 4)), 1, 0, 32'h0);
            if (i > 0) check("b2b_wb_valid", 70'(obs_wb_valid), 70'(1));
        end
        step(1, 0, nop, 1, 0, 32'h0);

        // Reset in WAIT discards the load; late rvalid is ignored.
        step(1, 1, mk(1, 3'd2, 1, 5'd9, 32'h0000_4000, 32'h1c00_0200), 1, 0, 32'h0);
        step(1, 0, nop, 1, 0, 32'h0);
        step(0, 0, nop, 1, 0, 32'h0);
        step(1, 0, nop, 1, 1, 32'hBAD0_BAD0);
        check("rst_wait_wb_valid", 70'(obs_wb_valid), 70'(0));
        step(1, 0, nop, 1, 1, 32'hBAD0_BAD1);
        check("rst_wait_wb_valid2", 70'(obs_wb_valid), 70'(0));

        // Randomized traffic, including stray rvalid and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 3) != 0), rand_ins(),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
